// File: rtl/lpc_pkg.sv
// Shared types and helpers for the LPC all-pole synthesis filter.
package lpc_pkg;

  localparam int ORDER_DEF = 10;
  localparam int W_DEF     = 16;
  localparam int CW_DEF    = 16;
  localparam int FRAC_DEF  = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_RND,
    ST_OUT
  } state_t;

  function automatic int acc_w(input int w, input int cw, input int order);
    return w + cw + $clog2(order) + 2;
  endfunction

  // A single-tap filter still needs a one-bit index.
  function automatic int addr_w(input int order);
    return (order > 1) ? $clog2(order) : 1;
  endfunction

  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/lpc_coef_bank.sv
// Double-buffered coefficient store: shadow bank written freely, copied to the
// active bank only while the filter is idle.
module lpc_coef_bank
  import lpc_pkg::*;
#(
  parameter int ORDER = ORDER_DEF,
  parameter int CW    = CW_DEF,
  parameter int AW    = addr_w(ORDER_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [CW-1:0] i_data,
  input  logic          i_swap,
  input  logic          i_idle,
  input  logic [AW-1:0] i_rd_idx,
  output logic [CW-1:0] o_rd_coef
);

  logic [CW-1:0] r_shadow [ORDER];
  logic [CW-1:0] r_active [ORDER];
  logic          r_swap_pend;
  logic          w_copy;

  assign w_copy    = i_idle && (r_swap_pend || i_swap);
  assign o_rd_coef = r_active[i_rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: both banks are register arrays that must read as zero after reset
      // (passthrough filter), so every entry is cleared; a RAM could not be.
      for (int i = 0; i < ORDER; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_swap_pend <= 1'b0;
    end else begin
      if (i_we && (int'(i_addr) < ORDER)) r_shadow[i_addr] <= i_data;
      // NOTE: non-blocking assignment makes the copy read the shadow value from
      // before this cycle's write, so a write and swap to one address take the old value.
      if (w_copy) begin
        r_active    <= r_shadow;
        r_swap_pend <= 1'b0;
      end else if (i_swap) begin
        r_swap_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lpc_synth_iir.sv
// All-pole LPC synthesis filter with one time-multiplexed MAC.
// Define SYNTH_SAT_EN to clamp the output and enable the sticky sat_flag.
module lpc_synth_iir
  import lpc_pkg::*;
#(
  parameter  int ORDER = ORDER_DEF,
  parameter  int W     = W_DEF,
  parameter  int CW    = CW_DEF,
  parameter  int FRAC  = FRAC_DEF,
  localparam int AW    = addr_w(ORDER),
  localparam int ACC_W = acc_w(W, CW, ORDER)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic          coef_swap,
  input  logic          clr_hist,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic          sat_flag
);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (FRAC - 1);

  state_t                    r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [AW-1:0]      r_k;
  logic signed [W-1:0]       r_hist [ORDER];
  logic        [W-1:0]       r_out_data;
  logic                      r_out_valid;
  logic                      r_in_ready;
  logic                      r_busy;
  logic        [CW-1:0]      w_coef;
  logic signed [W+CW-1:0]    w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_x_ext;
  logic signed [ACC_W-1:0]   w_rnd;

  lpc_coef_bank #(
    .ORDER (ORDER),
    .CW    (CW),
    .AW    (AW)
  ) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .i_we      (coef_we),
    .i_addr    (coef_addr),
    .i_data    (coef_data),
    .i_swap    (coef_swap),
    .i_idle    (r_state == ST_IDLE),
    .i_rd_idx  (r_k),
    .o_rd_coef (w_coef)
  );

  // r_k indexes tap k-1: hist[0] holds y[n-1], matched with a_1.
  assign w_prod     = (W+CW)'(r_hist[r_k]) * (W+CW)'($signed(w_coef));
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_x_ext    = ACC_W'($signed(in_data));
  assign w_rnd      = (r_acc + RND_HALF) >>> FRAC;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

`ifdef SYNTH_SAT_EN
  logic r_sat;
  assign sat_flag = r_sat;
`else
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_k         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      for (int i = 0; i < ORDER; i++) r_hist[i] <= '0;
`ifdef SYNTH_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Clearing and accepting may coincide; the new sample then sees zero history.
          if (clr_hist) begin
            for (int i = 0; i < ORDER; i++) r_hist[i] <= '0;
          end
          if (in_valid) begin
            r_acc      <= w_x_ext <<< FRAC;
            r_k        <= '0;
            r_state    <= ST_MAC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_k == AW'(ORDER - 1)) r_state <= ST_RND;
          else r_k <= r_k + AW'(1);
        end
        ST_RND: begin
`ifdef SYNTH_SAT_EN
          r_out_data <= W'(sat_narrow(64'(w_rnd), W));
          if (sat_narrow(64'(w_rnd), W) != 64'(w_rnd)) r_sat <= 1'b1;
`else
          r_out_data <= W'(64'(w_rnd));
`endif
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_hist[0] <= r_out_data;
            for (int i = 1; i < ORDER; i++) r_hist[i] <= r_hist[i-1];
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_synth_iir.sv
// Self-checking bench for lpc_synth_iir: directed tables, corner sequences and
// randomized traffic against a plain-arithmetic filter model.
module tb_lpc_synth_iir;

  localparam int ORDER = 10;
  localparam int W     = 16;
  localparam int CW    = 16;
  localparam int FRAC  = 13;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic          coef_swap;
  logic          clr_hist;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          sat_flag;

  lpc_synth_iir #(
    .ORDER (ORDER),
    .W     (W),
    .CW    (CW),
    .FRAC  (FRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_swap (coef_swap),
    .clr_hist  (clr_hist),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .sat_flag  (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_shadow [ORDER];
  longint m_active [ORDER];
  longint m_hist   [ORDER];   // m_hist[0] = y[n-1]
  bit     m_sat;

  function automatic void model_reset();
    foreach (m_shadow[i]) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
      m_hist[i]   = 0;
    end
    m_sat = 1'b0;
  endfunction

  function automatic longint model_y(input longint x);
    longint acc, r, y, hi, lo;
    acc = x * (longint'(1) << FRAC);
    for (int k = 0; k < ORDER; k++) acc += m_hist[k] * m_active[k];
    r  = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
`ifdef SYNTH_SAT_EN
    y = r;
    if (r > hi) begin y = hi; m_sat = 1'b1; end
    if (r < lo) begin y = lo; m_sat = 1'b1; end
`else
    y = r & ((longint'(1) << W) - 1);
    if (y > hi) y -= (longint'(1) << W);
`endif
    return y;
  endfunction

  function automatic void model_commit(input longint y);
    for (int k = ORDER - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = y;
  endfunction

  // ---------------- drivers ----------------
  // One idle cycle of coefficient / history control.
  task automatic idle_op(input bit we, input int addr, input longint data,
                         input bit swap, input bit clr);
    coef_we   = we;
    coef_addr = AW'(addr);
    coef_data = CW'(data);
    coef_swap = swap;
    clr_hist  = clr;
    @(posedge clk); #1;
    coef_we   = 1'b0;
    coef_swap = 1'b0;
    clr_hist  = 1'b0;
    if (swap) m_active = m_shadow;
    if (we && addr < ORDER) m_shadow[addr] = data;
    if (clr) foreach (m_hist[i]) m_hist[i] = 0;
  endtask

  // swap_at: 0 none, 1 together with the accept, >=2 pulsed that many cycles after it.
  task automatic run_sample(input longint x, input int stall, input int swap_at,
                            input string tag, output longint y, output int lat);
    int guard;
    longint exp_y;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " in_ready"}, longint'(in_ready), 1);
    if (swap_at == 1) m_active = m_shadow;
    exp_y = model_y(x);
    in_data   = W'(x);
    in_valid  = 1'b1;
    coef_swap = (swap_at == 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    coef_swap = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      coef_swap = (swap_at >= 2 && lat == swap_at);
      @(posedge clk); #1;
      lat++;
    end
    coef_swap = 1'b0;
    if (swap_at >= 2) m_active = m_shadow;
    check({tag, " latency"}, lat, ORDER + 2);
    y = longint'($signed(out_data));
    check({tag, " y"}, y, exp_y);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, " stall out_valid"}, longint'(out_valid), 1);
      check({tag, " stall out_data"}, longint'($signed(out_data)), exp_y);
      check({tag, " stall in_ready"}, longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    model_commit(exp_y);
    check({tag, " sat_flag"}, longint'(sat_flag), longint'(m_sat));
  endtask

  typedef struct {
    bit     set_a1;
    longint a1;
    bit     clr;
    longint x;
    longint exp_y;
  } vec_t;

  vec_t   vecs [6];
  longint y;
  int     lat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 0,    0, 1000, 1000};
    vecs[1] = '{1, 4096, 1, 8192, 8192};
    vecs[2] = '{0, 0,    0, 0,    4096};
    vecs[3] = '{0, 0,    0, 0,    2048};
    vecs[4] = '{0, 0,    0, 0,    1024};
    vecs[5] = '{0, 0,    0, 0,    512};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; coef_swap = 1'b0; clr_hist = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset in_ready", longint'(in_ready), 1);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset out_data", longint'(out_data), 0);
    check("reset busy", longint'(busy), 0);
    check("reset sat_flag", longint'(sat_flag), 0);

    // Passthrough and first-order impulse response.
    foreach (vecs[i]) begin
      if (vecs[i].set_a1) begin
        idle_op(1'b1, 0, vecs[i].a1, 1'b0, 1'b0);
        idle_op(1'b0, 0, 0, 1'b1, vecs[i].clr);
      end else if (vecs[i].clr) begin
        idle_op(1'b0, 0, 0, 1'b0, 1'b1);
      end
      run_sample(vecs[i].x, 0, 0, $sformatf("vec%0d", i), y, lat);
      check($sformatf("vec%0d table", i), y, vecs[i].exp_y);
    end

    // Overflow: a1 = 1.5, x = 30000 repeated.
    idle_op(1'b1, 0, 12288, 1'b0, 1'b0);
    idle_op(1'b0, 0, 0, 1'b1, 1'b1);
    run_sample(30000, 0, 0, "ovf0", y, lat);
    check("ovf0 const", y, 30000);
    run_sample(30000, 0, 0, "ovf1", y, lat);
`ifdef SYNTH_SAT_EN
    check("ovf1 const", y, 32767);
    check("ovf sat_flag", longint'(sat_flag), 1);
`else
    check("ovf1 const", y, 9464);
    check("ovf sat_flag", longint'(sat_flag), 0);
`endif
    run_sample(30000, 0, 0, "ovf2", y, lat);

    // Backpressure holds the output and shifts history exactly once.
    idle_op(1'b1, 0, 4096, 1'b0, 1'b0);
    idle_op(1'b0, 0, 0, 1'b1, 1'b1);
    run_sample(1000, 5, 0, "bp0", y, lat);
    check("bp0 const", y, 1000);
    run_sample(0, 0, 0, "bp1", y, lat);
    check("bp1 const", y, 500);

    // Swap during MAC applies to the next sample; swap with accept applies at once.
    idle_op(1'b1, 0, 0, 1'b0, 1'b0);
    idle_op(1'b0, 0, 0, 1'b1, 1'b1);
    run_sample(8192, 0, 0, "sw0", y, lat);
    idle_op(1'b1, 0, 4096, 1'b0, 1'b0);
    run_sample(100, 0, 3, "sw1", y, lat);
    check("sw1 old coefs", y, 100);
    run_sample(0, 0, 0, "sw2", y, lat);
    check("sw2 new coefs", y, 50);
    idle_op(1'b1, 0, 8192, 1'b0, 1'b0);
    run_sample(10, 0, 1, "sw3", y, lat);
    check("sw3 swap with accept", y, 60);
    idle_op(1'b1, 0, 2048, 1'b0, 1'b0);
    idle_op(1'b1, 0, -4096, 1'b1, 1'b0);
    run_sample(0, 0, 0, "sw4", y, lat);
    check("sw4 pre-write copy", y, 15);

    // Reset mid-MAC drops the sample and restores passthrough.
    in_data = W'(1234); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst busy before", longint'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst out_valid", longint'(out_valid), 0);
    check("midrst busy", longint'(busy), 0);
    check("midrst in_ready", longint'(in_ready), 1);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    run_sample(500, 0, 0, "postrst", y, lat);
    check("postrst const", y, 500);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int ops;
      ops = $urandom_range(0, 3);
      for (int o = 0; o < ops; o++) begin
        idle_op(($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                longint'($urandom_range(0, 4095)) - 2048,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      end
      run_sample(longint'($urandom_range(0, 40000)) - 20000, $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? 1 : (($urandom_range(0, 3) == 0) ? 3 : 0),
                 $sformatf("rnd%0d", n), y, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
